// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the RV32I multicycle controller and ALU
// Purpose: state codes, opcode constants, ALUOp and ALUControl encodings.
// Ports: none (package).
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle
// Purpose: groups instruction fields, ALU flag and all datapath controls.
// Ports: master = controller (drives controls, reads op/funct/Zero);
//        slave  = datapath (drives op/funct/Zero, reads controls).
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - combinational ALUOp/funct to ALUControl decode
// Purpose: maps the FSM's ALUOp plus instruction fields to the ALU operation.
// Ports: alu_op (in), funct3 (in), op_b5 (in, opcode bit 5), funct7b5 (in),
//        alu_control (out).
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op bit 5 set) can encode sub; addi with bit 30 set stays add.
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for an RV32I multicycle datapath
// Purpose: sequences lw/sw/R-type/I-type/beq/jal through one-cycle states and
//          drives datapath enables, mux selects, ImmSrc and ALUControl.
// Ports: clk (in), rst_n (in, async active-low), bus (multicycle_controller_if.master).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.master       bus
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_update, branch;
  logic       ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; anything unrecognised falls back to FETCH so the FSM never locks up.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_d = S_MEMREAD;
        else if (bus.op == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op_b5       (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.ALUControl)
  );

  // ImmSrc depends on the opcode alone, independent of state.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Write enables are gated by rst_n so nothing is written while reset is held,
  // even though state_q already reads FETCH.
  assign bus.PCWrite   = rst_n & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite   = rst_n & ir_write;
  assign bus.MemWrite  = rst_n & mem_write;
  assign bus.RegWrite  = rst_n & reg_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mw, rw, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
  } exp_t;

  logic clk;
  logic rst_n;
  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   release_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state s.
  function automatic exp_t model(input state_t s, input logic [6:0] opv, input logic [2:0] f3,
                                 input logic f7, input logic z, input bit in_rst);
    exp_t e;
    e = '0;
    e.st = s;
    e.imm = (opv == OP_SW) ? 2'b01 : (opv == OP_BEQ) ? 2'b10 : (opv == OP_JAL) ? 2'b11 : 2'b00;
    case (s)
      S_FETCH:    begin e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.rs = 2'b10; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.rs = 2'b01; e.rw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.mw = 1; end
      S_EXECUTER: begin e.sa = 2'b10; e.alu = funct_alu(f3, opv[5], f7); end
      S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(f3, opv[5], f7); end
      S_ALUWB:    e.rw = 1;
      S_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      default:    ;
    endcase
    if (in_rst) begin
      e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0;
    end
    return e;
  endfunction

  // Instruction-level path through the FSM.
  task automatic path_of(input logic [6:0] opv, output state_t p[$]);
    p = {};
    p.push_back(S_FETCH);
    p.push_back(S_DECODE);
    case (opv)
      OP_LW:    begin p.push_back(S_MEMADR); p.push_back(S_MEMREAD); p.push_back(S_MEMWB); end
      OP_SW:    begin p.push_back(S_MEMADR); p.push_back(S_MEMWRITE); end
      OP_RTYPE: begin p.push_back(S_EXECUTER); p.push_back(S_ALUWB); end
      OP_ITYPE: begin p.push_back(S_EXECUTEI); p.push_back(S_ALUWB); end
      OP_BEQ:   p.push_back(S_BEQ);
      OP_JAL:   begin p.push_back(S_JAL); p.push_back(S_ALUWB); end
      default:  ;
    endcase
  endtask

  // Advance to the next cycle and drive Zero (zmode 0/1 fixed, 2 random).
  task automatic step(input int zmode);
    @(posedge clk);
    #1;
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 0;
    end
    bus.Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
  endtask

  task automatic run_instr(input logic [6:0] opv, input logic [2:0] f3, input logic f7, input int zmode);
    state_t p[$];
    path_of(opv, p);
    foreach (p[i]) begin
      step(zmode);
      if (i == 0) begin
        bus.op = opv; bus.funct3 = f3; bus.funct7b5 = f7;
      end
      exp_q.push_back(model(p[i], opv, f3, f7, bus.Zero, 1'b0));
    end
  endtask

  // sw aborted by an asynchronous reset while in MEMWRITE.
  task automatic sw_with_reset;
    state_t p[$];
    path_of(OP_SW, p);
    for (int i = 0; i < 3; i++) begin
      step(2);
      if (i == 0) begin
        bus.op = OP_SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      end
      exp_q.push_back(model(p[i], OP_SW, 3'b010, 1'b0, bus.Zero, 1'b0));
    end
    step(2);
    chk("memwrite_before_reset", 32'(bus.MemWrite), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.push_back(model(S_FETCH, OP_SW, 3'b010, 1'b0, bus.Zero, 1'b1));
    #1;
    chk("async_reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("async_reset_memwrite", 32'(bus.MemWrite), 32'd0);
    step(2);
    exp_q.push_back(model(S_FETCH, OP_SW, 3'b010, 1'b0, bus.Zero, 1'b1));
    release_pending = 1;
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = {bus.state, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
           bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl};
      chk($sformatf("cycle_state%0d", e.st), 32'(a), 32'(e));
    end
  end

  logic [6:0] op_pool [7];

  initial begin
    op_pool = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL, 7'b1111111};
    rst_n = 1'b0;
    bus.op = OP_LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    #1;
    chk("reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("reset_irwrite", 32'(bus.IRWrite), 32'd0);
    chk("reset_pcwrite", 32'(bus.PCWrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0);
      exp_q.push_back(model(S_FETCH, bus.op, bus.funct3, bus.funct7b5, bus.Zero, 1'b1));
    end
    release_pending = 1;

    run_instr(OP_LW,    3'b010, 1'b0, 2);
    run_instr(OP_SW,    3'b010, 1'b0, 2);
    run_instr(OP_RTYPE, 3'b000, 1'b1, 2);
    run_instr(OP_ITYPE, 3'b000, 1'b1, 2);
    run_instr(OP_RTYPE, 3'b111, 1'b0, 2);
    run_instr(OP_RTYPE, 3'b110, 1'b0, 2);
    run_instr(OP_ITYPE, 3'b010, 1'b0, 2);
    run_instr(OP_BEQ,   3'b000, 1'b0, 1);
    run_instr(OP_BEQ,   3'b000, 1'b0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 2);
    run_instr(OP_JAL,   3'b000, 1'b0, 2);
    sw_with_reset();
    run_instr(OP_LW,    3'b010, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] opv;
      opv = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 6)];
      run_instr(opv, 3'($urandom), 1'($urandom), 2);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; encodings are fixed for RV32I subset lw, sw, R-type, I-type ALU, beq, jal.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  opcode from instruction register.
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag, current cycle.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  output  1 each  datapath enables/select.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath muxes.
REQ-010 ALUControl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 state  output  4  current state code, debug only.

Function
REQ-012 Moore FSM; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, each one cycle.
REQ-013 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTER (0110011), EXECUTEI (0010011), BEQ (1100011), JAL (1101111); MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-014 Unknown opcode in DECODE SHALL return to FETCH with no write enable asserted; no lockup.
REQ-015 Per state (unlisted outputs 0; ALUOp internal): FETCH IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
REQ-016 DECODE ALUSrcA=01, ALUSrcB=01, ALUOp=00; MEMADR ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-017 MEMREAD AdrSrc=1, ResultSrc=00; MEMWB ResultSrc=01, RegWrite=1; MEMWRITE AdrSrc=1, MemWrite=1.
REQ-018 EXECUTER ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI ALUSrcA=10, ALUSrcB=01, ALUOp=10; ALUWB ResultSrc=00, RegWrite=1.
REQ-019 BEQ ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; JAL ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-020 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinational on Zero, same cycle.
REQ-021 ImmSrc from op only: sw 01, beq 10, jal 11, all others 00.
REQ-022 ALUControl: ALUOp 00 -> 000; 01 -> 001; 10 -> by funct3: 000 -> 001 if op[5] AND funct7b5 else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-023 ALUOp 11 SHALL never occur; if decoded, ALUControl=000.
REQ-024 Instruction fields SHALL be sampled combinationally each cycle; no internal copy of op.

Reset
REQ-025 rst_n low SHALL force state to FETCH immediately, regardless of clk.
REQ-026 While rst_n low, PCWrite, IRWrite, MemWrite, RegWrite SHALL be 0; other outputs at FETCH values.
REQ-027 Reset mid-instruction (e.g. in MEMWRITE) SHALL abort it; first edge after release enters DECODE.

Structure
REQ-028 State codes, opcode constants, ALUOp and ALUControl encodings SHALL reside in a shared package used also by the ALU.
REQ-029 ALU control decode (REQ-022/023) SHALL be sub-module alu_decoder, purely combinational; FSM and ImmSrc stay in top.

Verification
REQ-030 lw (op=0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in MEMWB with ResultSrc=01; 5 cycles.
REQ-031 sw (op=0100011): MemWrite=1 exactly in 4th cycle, ImmSrc=01, back to FETCH in 5th.
REQ-032 R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER; same with op=0010011 (addi, funct7b5=1) -> 000.
REQ-033 beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; ALUControl=001 both.
REQ-034 op=1111111 in DECODE -> FETCH next cycle, no enable asserted; jal -> JAL,ALUWB, PCWrite=1 in JAL.
REQ-035 rst_n low asynchronously mid MEMWRITE -> state=FETCH and MemWrite=0 before next clk edge.
